// File: rtl/prf_scoreboard_if.sv
// prf_scoreboard_if: allocation, write-back, read and status bundle for prf_scoreboard.
interface prf_scoreboard_if #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int N_RD      = 4,
  parameter int N_WB      = 3,
  parameter int N_ALLOC   = 2
);
  localparam int PW = $clog2(NUM_PREGS);
  logic [N_ALLOC-1:0]             alloc_valid;
  logic [N_ALLOC-1:0][PW-1:0]     alloc_preg;
  logic [N_WB-1:0]                wb_valid;
  logic [N_WB-1:0][PW-1:0]        wb_preg;
  logic [N_WB-1:0][DATA_W-1:0]    wb_data;
  logic [N_RD-1:0][PW-1:0]        rd_preg1;
  logic [N_RD-1:0][PW-1:0]        rd_preg2;
  logic [N_RD-1:0][DATA_W-1:0]    rd_data1;
  logic [N_RD-1:0][DATA_W-1:0]    rd_data2;
  logic [N_RD-1:0]                rd_ready1;
  logic [N_RD-1:0]                rd_ready2;
  logic [PW:0]                    pending_count;
  logic                           wb_conflict;
  logic                           clr_conflict;
  modport master (
    output alloc_valid, alloc_preg, wb_valid, wb_preg, wb_data, rd_preg1, rd_preg2, clr_conflict,
    input  rd_data1, rd_data2, rd_ready1, rd_ready2, pending_count, wb_conflict
  );
  modport slave (
    input  alloc_valid, alloc_preg, wb_valid, wb_preg, wb_data, rd_preg1, rd_preg2, clr_conflict,
    output rd_data1, rd_data2, rd_ready1, rd_ready2, pending_count, wb_conflict
  );
endinterface

// File: rtl/prf_scoreboard.sv
// prf_scoreboard: physical register file with ready scoreboard, occupancy count and WB conflict flag.
// Define PRF_WB_BYPASS_EN to forward same-cycle write-backs to the read ports.
module prf_scoreboard #(
  parameter int NUM_PREGS = 64,
  parameter int DATA_W    = 32,
  parameter int N_RD      = 4,
  parameter int N_WB      = 3,
  parameter int N_ALLOC   = 2
) (
  input logic clk,
  input logic rst,
  prf_scoreboard_if.slave bus
);
  localparam int PW = $clog2(NUM_PREGS);
  logic [NUM_PREGS-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_PREGS-1:0]             ready_q, ready_d;
  logic [PW:0]                      pend_q, pend_d;
  logic                             conf_q, collide;
  logic [N_RD-1:0][DATA_W-1:0]      rdata1, rdata2;
  logic [N_RD-1:0]                  rrdy1, rrdy2;
  // Ascending port order makes the highest-index WB win; alloc is applied last so it wins over WB.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    collide = 1'b0;
    for (int w = 0; w < N_WB; w++)
      if (bus.wb_valid[w] && bus.wb_preg[w] != '0) begin
        data_d[bus.wb_preg[w]]  = bus.wb_data[w];
        ready_d[bus.wb_preg[w]] = 1'b1;
        for (int v = w + 1; v < N_WB; v++)
          if (bus.wb_valid[v] && bus.wb_preg[v] == bus.wb_preg[w]) collide = 1'b1;
      end
    for (int a = 0; a < N_ALLOC; a++)
      if (bus.alloc_valid[a] && bus.alloc_preg[a] != '0) ready_d[bus.alloc_preg[a]] = 1'b0;
    pend_d = '0;
    for (int i = 1; i < NUM_PREGS; i++) pend_d = pend_d + {{PW{1'b0}}, ~ready_d[i]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_q  <= '0;
      ready_q <= '1;
      pend_q  <= '0;
      conf_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
      pend_q  <= pend_d;
      conf_q  <= collide | (conf_q & ~bus.clr_conflict);
    end
  always_comb begin
    for (int r = 0; r < N_RD; r++) begin
      rdata1[r] = data_q[bus.rd_preg1[r]];
      rrdy1[r]  = ready_q[bus.rd_preg1[r]];
      rdata2[r] = data_q[bus.rd_preg2[r]];
      rrdy2[r]  = ready_q[bus.rd_preg2[r]];
`ifdef PRF_WB_BYPASS_EN
      for (int w = 0; w < N_WB; w++) begin
        if (bus.wb_valid[w] && bus.rd_preg1[r] != '0 && bus.wb_preg[w] == bus.rd_preg1[r]) begin
          rdata1[r] = bus.wb_data[w];
          rrdy1[r]  = 1'b1;
        end
        if (bus.wb_valid[w] && bus.rd_preg2[r] != '0 && bus.wb_preg[w] == bus.rd_preg2[r]) begin
          rdata2[r] = bus.wb_data[w];
          rrdy2[r]  = 1'b1;
        end
      end
`else
`endif
    end
  end
  assign bus.rd_data1      = rdata1;
  assign bus.rd_data2      = rdata2;
  assign bus.rd_ready1     = rrdy1;
  assign bus.rd_ready2     = rrdy2;
  assign bus.pending_count = pend_q;
  assign bus.wb_conflict   = conf_q;
endmodule
